// File: rtl/integrate_dump.sv
// Integrate-and-dump: accumulates len signed samples into an m-bit wrapping sum,
// then presents the sum with a sticky signed-overflow flag until it is consumed.
module integrate_dump #(
  parameter int n    = 16,
  parameter int m    = 24,
  parameter int len  = 256,
  parameter int cont = 0
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         start,
  input  logic [n-1:0] in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [m-1:0] out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         ovf
);

  localparam int cw = $clog2(len + 1);
  localparam logic [cw-1:0] last = cw'(len - 1);
  localparam bit cont_on = (cont != 0);

  typedef enum logic [1:0] {IDLE, INTEG, DUMP} state_t;

  state_t        state;
  logic [m-1:0]  acc;
  logic [cw-1:0] cnt;
  logic          wflag;
  logic [m:0]    sum;
  logic          sum_ovf;

  // One guard bit: the true signed result overflowed when it disagrees with bit m-1.
  assign sum     = {acc[m-1], acc} + {{(m + 1 - n){in[n-1]}}, in};
  assign sum_ovf = sum[m] ^ sum[m-1];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      wflag     <= 1'b0;
      out       <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start || cont_on) begin
            state    <= INTEG;
            acc      <= '0;
            cnt      <= '0;
            wflag    <= 1'b0;
            in_ready <= 1'b1;
            busy     <= 1'b1;
          end
        end
        INTEG: begin
          if (in_valid) begin
            acc   <= sum[m-1:0];
            wflag <= wflag | sum_ovf;
            cnt   <= cnt + cw'(1);
            if (cnt == last) begin
              out       <= sum[m-1:0];
              ovf       <= wflag | sum_ovf;
              out_valid <= 1'b1;
              in_ready  <= 1'b0;
              state     <= DUMP;
            end
          end
        end
        DUMP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (start || cont_on) begin
              state    <= INTEG;
              acc      <= '0;
              cnt      <= '0;
              wflag    <= 1'b0;
              in_ready <= 1'b1;
            end else begin
              state    <= IDLE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
            end
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_integrate_dump.sv
// Bench for integrate_dump: four instances (len=4 one-shot, len=4 continuous,
// m=17 overflow, len=1) checked every cycle against an integer window model.
module tb_integrate_dump;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  logic              start_s   [4];
  logic              in_valid_s[4];
  logic              out_ready_s[4];
  logic signed [15:0] in_s     [4];
  logic              in_ready_s[4];
  logic              out_valid_s[4];
  logic              busy_s    [4];
  logic              ovf_s     [4];
  logic [23:0]       out0, out1, out3;
  logic [16:0]       out2;

  localparam int m_of   [4] = '{24, 24, 17, 24};
  localparam int cont_of[4] = '{0, 1, 0, 0};
  localparam int len_of [4] = '{4, 4, 4, 1};

  integrate_dump #(.n(16), .m(24), .len(4), .cont(0)) u0 (
    .clk(clk), .clr(clr), .start(start_s[0]), .in(in_s[0]), .in_valid(in_valid_s[0]),
    .in_ready(in_ready_s[0]), .out(out0), .out_valid(out_valid_s[0]),
    .out_ready(out_ready_s[0]), .busy(busy_s[0]), .ovf(ovf_s[0]));
  integrate_dump #(.n(16), .m(24), .len(4), .cont(1)) u1 (
    .clk(clk), .clr(clr), .start(start_s[1]), .in(in_s[1]), .in_valid(in_valid_s[1]),
    .in_ready(in_ready_s[1]), .out(out1), .out_valid(out_valid_s[1]),
    .out_ready(out_ready_s[1]), .busy(busy_s[1]), .ovf(ovf_s[1]));
  integrate_dump #(.n(16), .m(17), .len(4), .cont(0)) u2 (
    .clk(clk), .clr(clr), .start(start_s[2]), .in(in_s[2]), .in_valid(in_valid_s[2]),
    .in_ready(in_ready_s[2]), .out(out2), .out_valid(out_valid_s[2]),
    .out_ready(out_ready_s[2]), .busy(busy_s[2]), .ovf(ovf_s[2]));
  integrate_dump #(.n(16), .m(24), .len(1), .cont(0)) u3 (
    .clk(clk), .clr(clr), .start(start_s[3]), .in(in_s[3]), .in_valid(in_valid_s[3]),
    .in_ready(in_ready_s[3]), .out(out3), .out_valid(out_valid_s[3]),
    .out_ready(out_ready_s[3]), .busy(busy_s[3]), .ovf(ovf_s[3]));

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic longint act_out(input int d);
    case (d)
      0: return longint'($signed(out0));
      1: return longint'($signed(out1));
      2: return longint'($signed(out2));
      default: return longint'($signed(out3));
    endcase
  endfunction

  // Two's-complement wrap of a true integer into m bits.
  function automatic longint wrap(input longint t, input int m);
    longint one = 1;
    longint r;
    r = t & ((one <<< m) - 1);
    if (r >= (one <<< (m - 1))) r = r - (one <<< m);
    return r;
  endfunction

  // Window model: phase 0 waiting, 1 collecting samples, 2 holding a result.
  int     ph   [4] = '{0, 0, 0, 0};
  longint acc  [4] = '{0, 0, 0, 0};
  int     nsamp[4] = '{0, 0, 0, 0};
  bit     wf   [4] = '{0, 0, 0, 0};
  longint eo   [4] = '{0, 0, 0, 0};
  bit     eov  [4] = '{0, 0, 0, 0};

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int d = 0; d < 4; d++) begin
        ph[d] = 0; acc[d] = 0; nsamp[d] = 0; wf[d] = 0; eo[d] = 0; eov[d] = 0;
      end
    end else begin
      for (int d = 0; d < 4; d++) begin
        longint one = 1;
        longint t;
        if (ph[d] == 0) begin
          if (start_s[d] || cont_of[d] != 0) begin
            ph[d] = 1; acc[d] = 0; nsamp[d] = 0; wf[d] = 0;
          end
        end else if (ph[d] == 1) begin
          if (in_valid_s[d]) begin
            t = acc[d] + longint'(in_s[d]);
            if (t >= (one <<< (m_of[d] - 1)) || t < -(one <<< (m_of[d] - 1))) wf[d] = 1;
            acc[d] = wrap(t, m_of[d]);
            nsamp[d]++;
            if (nsamp[d] == len_of[d]) begin
              eo[d] = acc[d]; eov[d] = wf[d]; ph[d] = 2;
            end
          end
        end else if (out_ready_s[d]) begin
          if (start_s[d] || cont_of[d] != 0) begin
            ph[d] = 1; acc[d] = 0; nsamp[d] = 0; wf[d] = 0;
          end else ph[d] = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run) begin
      for (int d = 0; d < 4; d++) begin
        chk($sformatf("d%0d in_ready", d), longint'(in_ready_s[d]), longint'(ph[d] == 1));
        chk($sformatf("d%0d busy", d), longint'(busy_s[d]), longint'(ph[d] != 0));
        chk($sformatf("d%0d out_valid", d), longint'(out_valid_s[d]), longint'(ph[d] == 2));
        chk($sformatf("d%0d ovf", d), longint'(ovf_s[d]), longint'(eov[d]));
        chk($sformatf("d%0d out", d), act_out(d), eo[d]);
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic feed(input int d, input int v);
    in_valid_s[d] = 1'b1;
    in_s[d] = 16'(v);
    cyc();
    in_valid_s[d] = 1'b0;
  endtask

  task automatic pulse_start(input int d);
    start_s[d] = 1'b1;
    cyc();
    start_s[d] = 1'b0;
  endtask

  task automatic take(input int d, input bit restart);
    out_ready_s[d] = 1'b1;
    start_s[d] = restart;
    cyc();
    out_ready_s[d] = 1'b0;
    start_s[d] = 1'b0;
  endtask

  initial begin
    int seq1 [10] = '{1, 1, 1, 1, 99, 2, 2, 2, 2, 99};
    int seq2 [7]  = '{-5, 0, 3, 0, 0, -7, 1};
    bit gap2 [7]  = '{1, 0, 1, 0, 0, 1, 1};
    for (int d = 0; d < 4; d++) begin
      start_s[d] = 0; in_valid_s[d] = 0; out_ready_s[d] = 0; in_s[d] = '0;
    end
    cyc(); cyc();
    chk("reset out0", act_out(0), 0);
    chk("reset busy0", longint'(busy_s[0]), 0);
    run = 1'b1;
    #2 clr = 1'b0;
    cyc();

    // Window 1,2,3,4 -> 10
    pulse_start(0);
    feed(0, 1); feed(0, 2); feed(0, 3); feed(0, 4);
    chk("sum10 out", act_out(0), 10);
    chk("sum10 valid", longint'(out_valid_s[0]), 1);
    chk("sum10 ovf", longint'(ovf_s[0]), 0);
    chk("sum10 model", eo[0], 10);
    take(0, 0);
    chk("sum10 idle busy", longint'(busy_s[0]), 0);

    // Samples with gaps -> -8
    pulse_start(0);
    for (int i = 0; i < 7; i++) begin
      if (gap2[i]) feed(0, seq2[i]); else cyc();
    end
    chk("gap out", act_out(0), -8);
    chk("gap raw", longint'(out0), 64'hFFFFF8);
    chk("gap model", eo[0], -8);
    take(0, 0);

    // Backpressure with in_valid busy; restart on the handshake edge
    pulse_start(0);
    feed(0, 5); feed(0, 6); feed(0, 7); feed(0, 8);
    for (int k = 1; k <= 3; k++) begin
      in_valid_s[0] = 1'b1; in_s[0] = 16'(100 * k);
      cyc();
    end
    in_valid_s[0] = 1'b0;
    chk("hold out", act_out(0), 26);
    chk("hold valid", longint'(out_valid_s[0]), 1);
    chk("hold in_ready", longint'(in_ready_s[0]), 0);
    take(0, 1);
    feed(0, 1); feed(0, 1); feed(0, 1); feed(0, 1);
    chk("after hold out", act_out(0), 4);
    take(0, 0);

    // Continuous windows
    out_ready_s[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid_s[1] = 1'b1; in_s[1] = 16'(seq1[i]);
      cyc();
      if (i == 3) chk("cont out4", act_out(1), 4);
      if (i == 8) chk("cont out8", act_out(1), 8);
    end
    in_valid_s[1] = 1'b0;
    chk("cont keep8", act_out(1), 8);
    chk("cont model", eo[1], 8);

    // m=17 overflow then clean window
    pulse_start(2);
    for (int i = 0; i < 4; i++) feed(2, 32767);
    chk("ovf out", act_out(2), -4);
    chk("ovf flag", longint'(ovf_s[2]), 1);
    take(2, 1);
    for (int i = 0; i < 4; i++) feed(2, 1);
    chk("post ovf out", act_out(2), 4);
    chk("post ovf flag", longint'(ovf_s[2]), 0);
    take(2, 0);

    // len=1
    pulse_start(3);
    feed(3, -3);
    chk("len1 out a", act_out(3), -3);
    take(3, 1);
    feed(3, 7);
    chk("len1 out b", act_out(3), 7);
    take(3, 0);

    // clr mid-window
    pulse_start(0);
    feed(0, 1); feed(0, 1);
    #2 clr = 1'b1;
    #1;
    chk("clr out0", act_out(0), 0);
    chk("clr in_ready0", longint'(in_ready_s[0]), 0);
    chk("clr busy0", longint'(busy_s[0]), 0);
    chk("clr out1", act_out(1), 0);
    chk("clr busy1", longint'(busy_s[1]), 0);
    chk("clr out2", act_out(2), 0);
    chk("clr out3", act_out(3), 0);
    cyc();
    #2 clr = 1'b0;
    cyc(); cyc();
    chk("after clr no valid", longint'(out_valid_s[0]), 0);
    pulse_start(0);
    feed(0, 1); feed(0, 1); feed(0, 1); feed(0, 1);
    chk("after clr out", act_out(0), 4);
    take(0, 0);
    cyc(); cyc();

    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
